// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer (store_buffer, sb_fwd_match).
package store_buffer_pkg;

   localparam int SB_DEPTH_DEFAULT = 4;
   // Word-address field sized for byte addresses up to 32 bits; narrower addresses zero-extend.
   localparam int SB_WADDR_W = 30;

   typedef struct packed {
      logic [SB_WADDR_W-1:0] waddr;
      logic [31:0]           data;
      logic [3:0]            we;
   } sb_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-vs-store-buffer address match: conflict OR, plus youngest-wins byte-lane
// forwarding when STORE_BUFFER_FWD_EN is defined.
module sb_fwd_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH_DEFAULT,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  sb_entry_t [DEPTH-1:0]  entries,
   input  logic [PTR_W-1:0]       head,
   input  logic [CNT_W-1:0]       count,
   input  logic [SB_WADDR_W-1:0]  ld_waddr,
   output logic                   conflict
`ifdef STORE_BUFFER_FWD_EN
   ,
   output logic [31:0]            fwd_data,
   output logic [3:0]             fwd_mask
`endif
);

   // Both vectors are indexed by age: 0 is the oldest (head) entry.
   logic [DEPTH-1:0][PTR_W-1:0] idx;
   logic [DEPTH-1:0]            hit;

   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign idx[k] = head + PTR_W'(k);
      assign hit[k] = (CNT_W'(k) < count) && (entries[idx[k]].waddr == ld_waddr);
   end

   assign conflict = |hit;

`ifdef STORE_BUFFER_FWD_EN
   // Walk oldest to youngest so the youngest enabled lane overwrites older ones.
   always_comb begin
      fwd_data = '0;
      fwd_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (hit[k] && entries[idx[k]].we[b]) begin
               fwd_mask[b]        = 1'b1;
               fwd_data[8*b +: 8] = entries[idx[k]].data[8*b +: 8];
            end
         end
      end
   end
`else
   logic unused_lanes;
   assign unused_lanes = ^entries;
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of word stores drained over a req/ack memory port.
// Optional load forwarding outputs are enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = SB_DEPTH_DEFAULT,
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [ADDR_W-1:0]       st_addr,
   input  logic [31:0]             st_data,
   input  logic [3:0]              st_we,
   output logic                    mem_req,
   input  logic                    mem_ack,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [3:0]              mem_we,
   input  logic [ADDR_W-1:0]       ld_addr,
   output logic                    ld_conflict,
`ifdef STORE_BUFFER_FWD_EN
   output logic [31:0]             ld_fwd_data,
   output logic [3:0]              ld_fwd_mask,
`endif
   output logic [$clog2(DEPTH):0]  sb_count,
   output logic                    sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t [DEPTH-1:0] entries;
   sb_entry_t             head_ent;
   logic [PTR_W-1:0]      head, tail;
   logic [CNT_W-1:0]      count, count_nxt;
   sb_state_t             state;
   logic                  push, pop;
   logic [SB_WADDR_W-1:0] ld_waddr;

   assign st_ready = (count != CNT_W'(DEPTH));
   // Empty-enable stores finish the handshake but never occupy an entry.
   assign push     = st_valid && st_ready && (st_we != 4'b0000);
   assign pop      = (state == BUSY) && mem_ack;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         entries[tail] <= '{waddr: SB_WADDR_W'(st_addr[ADDR_W-1:2]), data: st_data, we: st_we};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mem_req <= 1'b0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         count <= count_nxt;
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case (state)
            IDLE: if (count != '0) begin
               state   <= BUSY;
               mem_req <= 1'b1;
            end
            BUSY: if (pop && count_nxt == '0) begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   // The head only moves on a pop, so these hold steady while a request waits for ack.
   assign head_ent  = entries[head];
   assign mem_addr  = mem_req ? {head_ent.waddr[ADDR_W-3:0], 2'b00} : '0;
   assign mem_wdata = mem_req ? head_ent.data : '0;
   assign mem_we    = mem_req ? head_ent.we : '0;

   assign sb_count = count;
   assign sb_empty = (count == '0);
   assign ld_waddr = SB_WADDR_W'(ld_addr[ADDR_W-1:2]);

   sb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_match (
      .entries  (entries),
      .head     (head),
      .count    (count),
      .ld_waddr (ld_waddr),
      .conflict (ld_conflict)
`ifdef STORE_BUFFER_FWD_EN
      ,
      .fwd_data (ld_fwd_data),
      .fwd_mask (ld_fwd_mask)
`endif
   );

   logic unused_bits;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4, ADDR_W=32).
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data;
   logic [3:0]  st_we;
   logic        mem_req, mem_ack;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic [2:0]  sb_count;
   logic        sb_empty;
`ifdef STORE_BUFFER_FWD_EN
   logic [31:0] ld_fwd_data;
   logic [3:0]  ld_fwd_mask;
`endif

   int checks = 0;
   int errors = 0;

   store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_we       (st_we),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .ld_addr     (ld_addr),
      .ld_conflict (ld_conflict),
`ifdef STORE_BUFFER_FWD_EN
      .ld_fwd_data (ld_fwd_data),
      .ld_fwd_mask (ld_fwd_mask),
`endif
      .sb_count    (sb_count),
      .sb_empty    (sb_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        sv;
      logic [31:0] addr, data;
      logic [3:0]  we;
      logic        ack;
      logic [31:0] ld;
      logic        e_ready, e_req;
      logic [31:0] e_addr, e_data;
      logic [3:0]  e_we;
      int          e_count;
      logic        e_conf;
   } vec_t;

   function automatic vec_t mk(logic sv, logic [31:0] addr, logic [31:0] data, logic [3:0] we,
                               logic ack, logic [31:0] ld, logic e_ready, logic e_req,
                               logic [31:0] e_addr, logic [31:0] e_data, logic [3:0] e_we,
                               int e_count, logic e_conf);
      vec_t v;
      v.sv = sv; v.addr = addr; v.data = data; v.we = we; v.ack = ack; v.ld = ld;
      v.e_ready = e_ready; v.e_req = e_req; v.e_addr = e_addr; v.e_data = e_data;
      v.e_we = e_we; v.e_count = e_count; v.e_conf = e_conf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs after the falling edge and compare outputs before the next rise.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      st_valid = v.sv; st_addr = v.addr; st_data = v.data; st_we = v.we;
      mem_ack = v.ack; ld_addr = v.ld;
      #1;
      chk({tag, ".ready"}, 32'(st_ready), 32'(v.e_ready));
      chk({tag, ".req"},   32'(mem_req),  32'(v.e_req));
      chk({tag, ".addr"},  mem_addr,      v.e_addr);
      chk({tag, ".data"},  mem_wdata,     v.e_data);
      chk({tag, ".we"},    32'(mem_we),   32'(v.e_we));
      chk({tag, ".count"}, 32'(sb_count), 32'(v.e_count));
      chk({tag, ".empty"}, 32'(sb_empty), 32'(v.e_count == 0));
      chk({tag, ".conf"},  32'(ld_conflict), 32'(v.e_conf));
   endtask

   task automatic chk_fwd(input string tag, input logic [3:0] mask, input logic [31:0] data);
`ifdef STORE_BUFFER_FWD_EN
      chk({tag, ".fmask"}, 32'(ld_fwd_mask), 32'(mask));
      chk({tag, ".fdata"}, ld_fwd_data, data);
`else
      if (mask === 4'hx || data === 32'hx) $display("note: unexpected x");
`endif
   endtask

   vec_t tbl[$];

   initial begin
      // Single store with ack tied high, empty-enable store, fill/full/drain.
      tbl.push_back(mk(1, 'h100, 'hDEADBEEF, 4'hF, 1, 0,     1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h100,                 1, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h100,                 1, 1, 'h100, 'hDEADBEEF, 4'hF, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h100,                 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 'h300, 'h55, 4'h0, 1, 'h300,       1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h300,                 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h300,                 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 'h10, 'hA0, 4'hF, 0, 0,            1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 'h14, 'hA1, 4'hF, 0, 0,            1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 'h18, 'hA2, 4'hF, 0, 0,            1, 1, 'h10, 'hA0, 4'hF, 2, 0));
      tbl.push_back(mk(1, 'h1C, 'hA3, 4'hF, 0, 'h1C,         1, 1, 'h10, 'hA0, 4'hF, 3, 0));
      tbl.push_back(mk(1, 'h20, 'hA4, 4'hF, 0, 'h1C,         0, 1, 'h10, 'hA0, 4'hF, 4, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h20,                  0, 1, 'h10, 'hA0, 4'hF, 4, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h10,                  1, 1, 'h14, 'hA1, 4'hF, 3, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,                     1, 1, 'h18, 'hA2, 4'hF, 2, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,                     1, 1, 'h1C, 'hA3, 4'hF, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0,                     1, 0, 0, 0, 0, 0, 0));

      reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_we = 0; mem_ack = 0; ld_addr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.req",   32'(mem_req), 0);
      chk("rst.count", 32'(sb_count), 0);
      chk("rst.empty", 32'(sb_empty), 1);
      chk("rst.ready", 32'(st_ready), 1);
      chk("rst.conf",  32'(ld_conflict), 0);
      chk("rst.addr",  mem_addr, 0);
      chk_fwd("rst", 4'h0, 32'h0);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

      // Push and ack together at count 2 across several pointer wraps.
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, d, pa, pd;
         logic [3:0]  w, pw;
         a = 32'h1000 + 32'(4*i); d = 32'hC0DE0000 + 32'(i); w = 4'(i % 15 + 1);
         pa = 32'h1000 + 32'(4*(i-2)); pd = 32'hC0DE0000 + 32'(i-2); pw = 4'((i-2) % 15 + 1);
         if (i == 0)      apply(mk(1, a, d, w, 0, 0, 1, 0, 0, 0, 0, 0, 0), "w0");
         else if (i == 1) apply(mk(1, a, d, w, 0, 0, 1, 0, 0, 0, 0, 1, 0), "w1");
         else             apply(mk(1, a, d, w, 1, 0, 1, 1, pa, pd, pw, 2, 0), $sformatf("w%0d", i));
      end
      apply(mk(0, 0, 0, 0, 1, 0, 1, 1, 'h1028, 'hC0DE000A, 4'hB, 2, 0), "wt0");
      apply(mk(0, 0, 0, 0, 1, 0, 1, 1, 'h102C, 'hC0DE000B, 4'hC, 1, 0), "wt1");
      apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "wt2");

      // Same-word partial stores: conflict and youngest-wins forwarding.
      apply(mk(1, 'h200, 'h11, 4'h1, 0, 'h203,       1, 0, 0, 0, 0, 0, 0), "c0");
      chk_fwd("c0", 4'h0, 32'h0);
      apply(mk(1, 'h200, 'h00220000, 4'h4, 0, 'h203, 1, 0, 0, 0, 0, 1, 1), "c1");
      chk_fwd("c1", 4'h1, 32'h00000011);
      apply(mk(0, 0, 0, 0, 0, 'h203,                 1, 1, 'h200, 'h11, 4'h1, 2, 1), "c2");
      chk_fwd("c2", 4'h5, 32'h00220011);
      apply(mk(1, 'h200, 'h0000BB33, 4'h3, 0, 'h204, 1, 1, 'h200, 'h11, 4'h1, 2, 0), "c3");
      chk_fwd("c3", 4'h0, 32'h0);
      apply(mk(0, 0, 0, 0, 0, 'h200,                 1, 1, 'h200, 'h11, 4'h1, 3, 1), "c4");
      chk_fwd("c4", 4'h7, 32'h0022BB33);
      apply(mk(0, 0, 0, 0, 1, 'h200, 1, 1, 'h200, 'h11, 4'h1, 3, 1), "c5");
      apply(mk(0, 0, 0, 0, 1, 'h200, 1, 1, 'h200, 'h00220000, 4'h4, 2, 1), "c6");
      apply(mk(0, 0, 0, 0, 1, 'h200, 1, 1, 'h200, 'h0000BB33, 4'h3, 1, 1), "c7");
      apply(mk(0, 0, 0, 0, 1, 'h200, 1, 0, 0, 0, 0, 0, 0), "c8");

      // Reset in the middle of a drain with ack high.
      apply(mk(1, 'h40, 'hE0, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0), "r0");
      apply(mk(1, 'h44, 'hE1, 4'hF, 0, 0, 1, 0, 0, 0, 0, 1, 0), "r1");
      apply(mk(1, 'h48, 'hE2, 4'hF, 0, 0, 1, 1, 'h40, 'hE0, 4'hF, 2, 0), "r2");
      apply(mk(0, 0, 0, 0, 0, 'h44, 1, 1, 'h40, 'hE0, 4'hF, 3, 1), "r3");
      @(negedge clk);
      reset = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("ra%0d.req", i),   32'(mem_req), 0);
         chk($sformatf("ra%0d.count", i), 32'(sb_count), 0);
         chk($sformatf("ra%0d.addr", i),  mem_addr, 0);
         chk($sformatf("ra%0d.conf", i),  32'(ld_conflict), 0);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the store byte-lane aligner and data memory. It accepts word-aligned store packets (address, lane-aligned data, four byte write enables) in a single cycle and queues them in a FIFO. It drains them to a memory port that may stall, using a req/ack handshake. It also reports load/store address conflicts so the core can stall a load that would read stale memory.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store packet offered.
- st_ready  out  1  buffer can accept a packet this cycle.
- st_addr  in  ADDR_W  byte address; only bits [ADDR_W-1:2] are stored.
- st_data  in  32  lane-aligned write data.
- st_we  in  4  byte enables {we3,we2,we1,we0}.
- mem_req  out  1  head entry presented to memory.
- mem_ack  in  1  memory accepted the presented entry.
- mem_addr  out  ADDR_W  {entry word address, 2'b00}.
- mem_wdata  out  32  head entry data.
- mem_we  out  4  head entry byte enables.
- ld_addr  in  ADDR_W  address of the load currently in the memory stage.
- ld_conflict  out  1  some valid entry matches ld_addr[ADDR_W-1:2].
- sb_count  out  $clog2(DEPTH)+1  number of valid entries.
- sb_empty  out  1  sb_count == 0.

## Operation
- FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count register.
- st_ready = (sb_count != DEPTH). It is combinational from count only and never depends on mem_ack.
- Push happens on the clock edge where st_valid && st_ready.
  - A packet with st_we == 4'b0000 completes the handshake but is not enqueued.
- No coalescing: two stores to the same word occupy separate entries and drain in program order.
- Drain FSM states:
  - IDLE: mem_req = 0. Goes to BUSY when sb_count != 0.
  - BUSY: mem_req = 1, and mem_addr/mem_wdata/mem_we show the head entry and stay stable until mem_ack.
    - On mem_ack: pop the head.
    - Stay in BUSY if count after the pop is nonzero; the next entry appears the following cycle. Otherwise go to IDLE.
- mem_ack is ignored while in IDLE.
- Push and pop on the same edge leave count unchanged.
  - When full, no push is accepted even if a pop occurs that edge.
- ld_conflict is combinational. It is 1 when any valid entry's word address equals ld_addr[ADDR_W-1:2], whatever its byte enables.
- Reset, including in mid-drain, does the following:
  - Empties the buffer: count = 0, pointers = 0, state = IDLE.
  - An ack arriving in the reset cycle is ignored.

## Timing
- Reset values: mem_req 0, sb_count 0, sb_empty 1, st_ready 1, ld_conflict 0.
- mem_addr, mem_wdata, mem_we and (with the configuration macro) ld_fwd_data/ld_fwd_mask are 0.
- Latency: for a store accepted at edge N into an empty buffer, mem_req is 1 from edge N+1.
- Back-to-back drain: with mem_ack held at 1, one entry retires per cycle.
- sb_count and sb_empty update at the push/pop edge.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - Adds outputs ld_fwd_data (32) and ld_fwd_mask (4).
  - Per byte lane, the data comes from the youngest valid matching entry whose we bit is set, and that mask bit is 1.
  - Lanes with no match give mask 0 and data 0.
  - The core merges these lanes over memory read data instead of stalling.
  - ld_conflict remains present.
- Undefined: these ports and all merge logic are absent; the core must stall on ld_conflict.

## Structure
- Shared package store_buffer_pkg contains:
  - sb_entry_t typedef {word address, data[31:0], we[3:0]}.
  - sb_state_t enum {IDLE, BUSY}.
  - Default DEPTH constant.
- One sub-module, sb_fwd_match: per-entry address compare, age-ordered byte-lane select, and the conflict OR.
  - It is instantiated once; the merge portion sits under STORE_BUFFER_FWD_EN.

## Test plan
- Single store to 0x100 (data 0xDEADBEEF, we 4'b1111) with mem_ack tied to 1 → mem_req high for exactly one cycle from edge N+1, carrying mem_addr 0x100, data 0xDEADBEEF, we 4'hF. Then sb_empty returns to 1.
- Fill to DEPTH=4 with mem_ack=0 → st_ready 0 and a fifth st_valid is not accepted. Release ack → entries drain in order, one per cycle, and st_ready rises after the first pop.
- Simultaneous push and ack with count 2 → count stays 2, and drain order is preserved across pointer wrap (more than 8 stores through a 4-entry buffer).
- Store with st_we=0 → st_ready handshake completes, count stays 0, and mem_req is never asserted.
- Entries at 0x200 with we 4'b0001 (data 0x11) and then 4'b0100 (data 0x00220000); load at 0x203 → ld_conflict 1. With the macro: ld_fwd_mask 4'b0101 and ld_fwd_data 0x00220011. Load at 0x204 → conflict 0 and mask 0.
- Reset asserted while in BUSY with 3 entries and mem_ack=1 → next cycle mem_req 0, sb_count 0, and no further memory writes occur.
